// File: rtl/lives_hud_pkg.sv
// rtl/lives_hud_pkg.sv - shared HUD state type and screen-position constants
// Used by the lives row and by the score display, which lines up with the same row.
package lives_hud_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_BLINK     = 2'd1,
        ST_GAME_OVER = 2'd2
    } hud_state_t;

    // Default geometry of the heart row; the score display anchors to these.
    localparam int HUD_TOP_LEFT_X = 16;
    localparam int HUD_TOP_LEFT_Y = 8;
    localparam int HUD_HEART_SIZE = 32;
    localparam int HUD_HEART_GAP  = 8;
    localparam int SLOT_PITCH     = HUD_HEART_SIZE + HUD_HEART_GAP;

endpackage

// File: rtl/lives_hud_controller_hud_slot_decoder.sv
// rtl/lives_hud_controller_hud_slot_decoder.sv - combinational icon-row slot decoder
// Ports:
//   pixel_x/pixel_y (in, 11)  current scan position
//   slot_hit        (out, 1)  pixel lies inside one of COUNT icon rectangles
//   slot_index      (out, 4)  which slot was hit (0 when no hit)
//   off_x/off_y     (out, 11) pixel position relative to the hit slot (0 when no hit)
module hud_slot_decoder #(
    parameter int X0    = 16,
    parameter int Y0    = 8,
    parameter int PITCH = 40,
    parameter int SIZE  = 32,
    parameter int COUNT = 5
) (
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic        slot_hit,
    output logic [3:0]  slot_index,
    output logic [10:0] off_x,
    output logic [10:0] off_y
);

    logic y_in;

    // Zero-extend to 12 bits so edges near the top of the 11-bit range cannot wrap.
    assign y_in = ({1'b0, pixel_y} >= 12'(Y0)) && ({1'b0, pixel_y} < 12'(Y0 + SIZE));

    // One independent compare pair per slot against constant edges; slots never
    // overlap, so at most one iteration matches.
    always_comb begin
        slot_hit   = 1'b0;
        slot_index = 4'd0;
        off_x      = 11'd0;
        off_y      = 11'd0;
        for (int k = 0; k < COUNT; k++) begin
            if (y_in &&
                ({1'b0, pixel_x} >= 12'(X0 + k * PITCH)) &&
                ({1'b0, pixel_x} <  12'(X0 + k * PITCH + SIZE))) begin
                slot_hit   = 1'b1;
                slot_index = 4'(k);
                off_x      = pixel_x - 11'(X0 + k * PITCH);
                off_y      = pixel_y - 11'(Y0);
            end
        end
    end

endmodule

// File: rtl/lives_hud_controller.sv
// rtl/lives_hud_controller.sv - life counter, blink sequencer and heart-row pixel mapper
// Ports:
//   clk, reset (sync, active-high)
//   pixelX/pixelY (in, 11)         scan position; outputs below follow one cycle later
//   startOfFrame, lifeLost, lifeGained, gameRestart (in, 1)  single-cycle events
//   offsetX/offsetY (out, 11)      heart-local pixel offset, 0 when not drawing
//   insideRectangle (out, 1)       pixel lies inside a visible heart
//   livesCount (out, 4), gameOver (out, 1)
module lives_hud_controller
    import lives_hud_pkg::*;
#(
    parameter int MAX_LIVES     = 5,
    parameter int INIT_LIVES    = 3,
    parameter int TOP_LEFT_X    = HUD_TOP_LEFT_X,
    parameter int TOP_LEFT_Y    = HUD_TOP_LEFT_Y,
    parameter int HEART_SIZE    = HUD_HEART_SIZE,
    parameter int HEART_GAP     = HUD_HEART_GAP,
    parameter int BLINK_FRAMES  = 8,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        lifeLost,
    input  logic        lifeGained,
    input  logic        gameRestart,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        insideRectangle,
    output logic [3:0]  livesCount,
    output logic        gameOver
);

    localparam int PITCH = HEART_SIZE + HEART_GAP;
    localparam int FCW   = $clog2(BLINK_FRAMES) + 1;
    localparam int TCW   = $clog2(BLINK_TOGGLES) + 1;
    localparam logic [FCW-1:0] FRAME_LAST  = FCW'(BLINK_FRAMES - 1);
    localparam logic [TCW-1:0] TOGGLE_LAST = TCW'(BLINK_TOGGLES - 1);
    localparam logic [3:0]     LIVES_MAX   = 4'(MAX_LIVES);
    localparam logic [3:0]     LIVES_INIT  = 4'(INIT_LIVES);

    hud_state_t     state_q, state_d;
    logic [3:0]     lives_q, lives_d;
    logic           phase_q, phase_d;
    logic [FCW-1:0] frame_q, frame_d;
    logic [TCW-1:0] toggle_q, toggle_d;

    logic [10:0]    offset_x_q, offset_y_q;
    logic           inside_q;

    logic           slot_hit;
    logic [3:0]     slot_index;
    logic [10:0]    slot_off_x, slot_off_y;
    logic           slot_visible;

    hud_slot_decoder #(
        .X0    (TOP_LEFT_X),
        .Y0    (TOP_LEFT_Y),
        .PITCH (PITCH),
        .SIZE  (HEART_SIZE),
        .COUNT (MAX_LIVES)
    ) u_slot_decoder (
        .pixel_x    (pixelX),
        .pixel_y    (pixelY),
        .slot_hit   (slot_hit),
        .slot_index (slot_index),
        .off_x      (slot_off_x),
        .off_y      (slot_off_y)
    );

    // The slot just past the last life is the one that blinks, so it tracks any
    // life gained while blinking.
    assign slot_visible = slot_hit && (state_q != ST_GAME_OVER) &&
                          ((slot_index < lives_q) ||
                           ((slot_index == lives_q) && (state_q == ST_BLINK) && phase_q));

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        phase_d  = phase_q;
        frame_d  = frame_q;
        toggle_d = toggle_q;
        if (gameRestart) begin
            state_d  = ST_ACTIVE;
            lives_d  = LIVES_INIT;
            phase_d  = 1'b0;
            frame_d  = '0;
            toggle_d = '0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (lifeLost && !lifeGained) begin
                        if (lives_q != 4'd0) begin
                            lives_d = lives_q - 4'd1;
                        end
                        frame_d  = '0;
                        toggle_d = '0;
                        phase_d  = 1'b1;
                        state_d  = ST_BLINK;
                    end else if (lifeGained && !lifeLost && (lives_q < LIVES_MAX)) begin
                        lives_d = lives_q + 4'd1;
                    end
                end
                ST_BLINK: begin
                    // lifeLost is deliberately ignored here: invulnerable while blinking.
                    if (lifeGained && (lives_q < LIVES_MAX)) begin
                        lives_d = lives_q + 4'd1;
                    end
                    if (startOfFrame) begin
                        if (frame_q == FRAME_LAST) begin
                            frame_d  = '0;
                            phase_d  = ~phase_q;
                            toggle_d = toggle_q + TCW'(1);
                            if (toggle_q == TOGGLE_LAST) begin
                                toggle_d = '0;
                                phase_d  = 1'b0;
                                state_d  = (lives_d == 4'd0) ? ST_GAME_OVER : ST_ACTIVE;
                            end
                        end else begin
                            frame_d = frame_q + FCW'(1);
                        end
                    end
                end
                ST_GAME_OVER: begin
                end
                default: begin
                    state_d = ST_ACTIVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACTIVE;
            lives_q    <= LIVES_INIT;
            phase_q    <= 1'b0;
            frame_q    <= '0;
            toggle_q   <= '0;
            offset_x_q <= 11'd0;
            offset_y_q <= 11'd0;
            inside_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            phase_q    <= phase_d;
            frame_q    <= frame_d;
            toggle_q   <= toggle_d;
            inside_q   <= slot_visible;
            offset_x_q <= slot_visible ? slot_off_x : 11'd0;
            offset_y_q <= slot_visible ? slot_off_y : 11'd0;
        end
    end

    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign insideRectangle = inside_q;
    assign livesCount      = lives_q;
    assign gameOver        = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_lives_hud_controller.sv
// tb/tb_lives_hud_controller.sv - scoreboard bench for lives_hud_controller
module tb_lives_hud_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] pixelX = 11'd0;
    logic [10:0] pixelY = 11'd0;
    logic        startOfFrame = 1'b0;
    logic        lifeLost = 1'b0;
    logic        lifeGained = 1'b0;
    logic        gameRestart = 1'b0;
    logic [10:0] offsetX, offsetY;
    logic        insideRectangle;
    logic [3:0]  livesCount;
    logic        gameOver;

    logic        probe = 1'b0;
    logic        sampled;

    typedef struct {
        logic        ins;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [3:0]  lv;
        logic        go;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    lives_hud_controller dut (
        .clk             (clk),
        .reset           (reset),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .startOfFrame    (startOfFrame),
        .lifeLost        (lifeLost),
        .lifeGained      (lifeGained),
        .gameRestart     (gameRestart),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .insideRectangle (insideRectangle),
        .livesCount      (livesCount),
        .gameOver        (gameOver)
    );

    // Monitor: a probed pixel sampled on an edge has its outputs ready just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            sampled = probe;
            #1;
            if (sampled) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL underflow: output presented with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    if (insideRectangle !== e.ins || offsetX !== e.ox || offsetY !== e.oy ||
                        livesCount !== e.lv || gameOver !== e.go) begin
                        failed++;
                        $display("FAIL check%0d: got ins=%0b off=(%0d,%0d) lives=%0d go=%0b, expected ins=%0b off=(%0d,%0d) lives=%0d go=%0b",
                                 e.id, insideRectangle, offsetX, offsetY, livesCount, gameOver,
                                 e.ins, e.ox, e.oy, e.lv, e.go);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [10:0] x, input logic [10:0] y, input logic p,
                         input logic sof, input logic lost, input logic gain,
                         input logic rst_g, input logic rst);
        @(negedge clk);
        pixelX = x; pixelY = y; probe = p; startOfFrame = sof;
        lifeLost = lost; lifeGained = gain; gameRestart = rst_g; reset = rst;
    endtask

    task automatic tick(input int n);
        repeat (n) drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ev(input logic lost, input logic gain, input logic rst_g);
        drive(11'd0, 11'd0, 1'b0, 1'b0, lost, gain, rst_g, 1'b0);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            drive(11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(1);
        end
    endtask

    task automatic chk(input int id, input logic [10:0] x, input logic [10:0] y, input logic rst,
                       input logic ins, input logic [10:0] ox, input logic [10:0] oy,
                       input logic [3:0] lv, input logic go);
        exp_t e;
        e.ins = ins; e.ox = ox; e.oy = oy; e.lv = lv; e.go = go; e.id = id;
        exp_q.push_back(e);
        drive(x, y, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rst);
    endtask

    initial begin
        tick(1);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk(1, 11'd0, 11'd0, 1'b1, 1'b0, 11'd0, 11'd0, 4'd3, 1'b0);      // reset values
        chk(2, 11'd16, 11'd8, 1'b0, 1'b1, 11'd0, 11'd0, 4'd3, 1'b0);     // slot 0 corner
        chk(3, 11'd48, 11'd8, 1'b0, 1'b0, 11'd0, 11'd0, 4'd3, 1'b0);     // gap
        chk(4, 11'd96, 11'd20, 1'b0, 1'b1, 11'd0, 11'd12, 4'd3, 1'b0);   // slot 2 visible
        chk(5, 11'd136, 11'd20, 1'b0, 1'b0, 11'd0, 11'd0, 4'd3, 1'b0);   // slot 3 hidden
        chk(6, 11'd47, 11'd39, 1'b0, 1'b1, 11'd31, 11'd31, 4'd3, 1'b0);  // last pixel of slot 0
        chk(7, 11'd47, 11'd40, 1'b0, 1'b0, 11'd0, 11'd0, 4'd3, 1'b0);    // below row
        // Lose a life: slot 2 blinks, starting visible.
        ev(1'b1, 1'b0, 1'b0);
        chk(8, 11'd100, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd2, 1'b0);
        ev(1'b1, 1'b0, 1'b0);                                             // ignored while blinking
        chk(9, 11'd100, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd2, 1'b0);
        frames(8);
        chk(10, 11'd100, 11'd10, 1'b0, 1'b0, 11'd0, 11'd0, 4'd2, 1'b0);
        chk(11, 11'd60, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd2, 1'b0);
        frames(8);
        chk(12, 11'd100, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd2, 1'b0);
        frames(31);                                                       // 47 frames total
        chk(13, 11'd100, 11'd10, 1'b0, 1'b0, 11'd0, 11'd0, 4'd2, 1'b0);
        frames(1);                                                        // back to ACTIVE
        chk(14, 11'd100, 11'd10, 1'b0, 1'b0, 11'd0, 11'd0, 4'd2, 1'b0);
        ev(1'b1, 1'b0, 1'b0);                                             // accepted in ACTIVE
        chk(15, 11'd60, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd1, 1'b0);
        frames(48);
        ev(1'b1, 1'b0, 1'b0);                                             // last life
        chk(16, 11'd20, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd0, 1'b0);
        frames(48);
        chk(17, 11'd20, 11'd10, 1'b0, 1'b0, 11'd0, 11'd0, 4'd0, 1'b1);
        ev(1'b0, 1'b1, 1'b0);                                             // ignored in GAME_OVER
        chk(18, 11'd20, 11'd10, 1'b0, 1'b0, 11'd0, 11'd0, 4'd0, 1'b1);
        ev(1'b0, 1'b0, 1'b1);
        chk(19, 11'd20, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd3, 1'b0);
        ev(1'b0, 1'b1, 1'b0);
        ev(1'b0, 1'b1, 1'b0);
        ev(1'b0, 1'b1, 1'b0);                                             // saturates at 5
        chk(20, 11'd180, 11'd39, 1'b0, 1'b1, 11'd4, 11'd31, 4'd5, 1'b0);
        chk(21, 11'd208, 11'd10, 1'b0, 1'b0, 11'd0, 11'd0, 4'd5, 1'b0);
        ev(1'b1, 1'b1, 1'b0);                                             // simultaneous: no change
        chk(22, 11'd180, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd5, 1'b0);
        frames(8);                                                        // would hide slot 4 if blinking
        chk(23, 11'd180, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd5, 1'b0);
        ev(1'b1, 1'b0, 1'b0);
        chk(24, 11'd180, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd4, 1'b0);
        frames(8);                                                        // slot 4 now hidden phase
        chk(25, 11'd180, 11'd10, 1'b0, 1'b0, 11'd0, 11'd0, 4'd4, 1'b0);
        ev(1'b0, 1'b1, 1'b0);                                             // gain while blinking
        chk(26, 11'd180, 11'd10, 1'b0, 1'b1, 11'd4, 11'd2, 4'd5, 1'b0);
        frames(3);
        chk(27, 11'd180, 11'd10, 1'b1, 1'b0, 11'd0, 11'd0, 4'd3, 1'b0);  // reset mid-blink
        chk(28, 11'd96, 11'd10, 1'b0, 1'b1, 11'd0, 11'd2, 4'd3, 1'b0);
        frames(8);
        chk(29, 11'd136, 11'd10, 1'b0, 1'b0, 11'd0, 11'd0, 4'd3, 1'b0);
        tick(2);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            tests_run++;
            failed++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
